// File: rtl/router_pkg.sv
// Shared router constants: data width, FIFO depth, header field positions and the stored-word layout.
package router_pkg;

    localparam int unsigned ROUTER_DATA_W     = 8;
    localparam int unsigned ROUTER_FIFO_DEPTH = 16;

    // Header byte layout: payload length in [7:2], destination address in [1:0].
    localparam int unsigned HDR_LEN_MSB  = 7;
    localparam int unsigned HDR_LEN_LSB  = 2;
    localparam int unsigned HDR_ADDR_MSB = 1;
    localparam int unsigned HDR_ADDR_LSB = 0;
    localparam int unsigned ROUTER_CNT_W = HDR_LEN_MSB - HDR_LEN_LSB + 1;

    typedef struct packed {
        logic                     hdr;
        logic [ROUTER_DATA_W-1:0] data;
    } router_word_t;

endpackage

// File: rtl/router_fifo_if.sv
// Write/read handshake bundle between router_reg/router_fsm, the per-port FIFO and the destination.
interface router_fifo_if
    import router_pkg::*;
#(
    parameter int unsigned WIDTH = ROUTER_DATA_W
);
    logic             write_enb;
    logic             read_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] data_out;

    modport master (
        output write_enb, read_enb, lfd_state, data_in,
        input  full, empty, data_out
    );

    modport slave (
        input  write_enb, read_enb, lfd_state, data_in,
        output full, empty, data_out
    );
endinterface

// File: rtl/router_fifo_mem.sv
// DEPTH x (WIDTH+1) storage: synchronous write, registered byte read, plus a combinational peek of the head word.
module router_fifo_mem
    import router_pkg::*;
#(
    parameter int unsigned DEPTH = ROUTER_FIFO_DEPTH,
    parameter int unsigned WIDTH = ROUTER_DATA_W,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH:0]   wr_word,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH:0]   rd_word_c,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_word;
        if (rd_en) rd_data <= mem[rd_addr][WIDTH-1:0];
    end

    // Head word is needed in the read cycle itself to load the packet counter.
    assign rd_word_c = mem[rd_addr];
endmodule

// File: rtl/router_fifo.sv
// Per-output-port packet FIFO of the 1x3 router with read-side packet length tracking.
// Build option ROUTER_FIFO_HIZ_EN: data_out tristates (all-Z) when idle instead of driving zero.
module router_fifo
    import router_pkg::*;
#(
    parameter int unsigned DEPTH = ROUTER_FIFO_DEPTH,
    parameter int unsigned WIDTH = ROUTER_DATA_W
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          soft_reset,
    router_fifo_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [ROUTER_CNT_W-1:0] count;
    logic                    idle_q;
    logic [WIDTH:0]          rd_word_c;
    logic [WIDTH-1:0]        rd_data;
    logic                    flush_c;
    logic                    do_wr_c;
    logic                    do_rd_c;
    logic                    unused_addr;

    assign bus.empty = (wr_ptr == rd_ptr);
    assign bus.full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign flush_c = !resetn || soft_reset;
    assign do_wr_c = bus.write_enb && !bus.full  && !flush_c;
    assign do_rd_c = bus.read_enb  && !bus.empty && !flush_c;

    // Destination address bits travel with the data but play no part in length tracking.
    assign unused_addr = ^rd_word_c[HDR_ADDR_MSB:HDR_ADDR_LSB];

    router_fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
        .clock     (clock),
        .wr_en     (do_wr_c),
        .wr_addr   (wr_ptr[AW-1:0]),
        .wr_word   ({bus.lfd_state, bus.data_in}),
        .rd_en     (do_rd_c),
        .rd_addr   (rd_ptr[AW-1:0]),
        .rd_word_c (rd_word_c),
        .rd_data   (rd_data)
    );

    // Pointers, packet counter and idle flag; a flush discards any partial packet.
    always_ff @(posedge clock) begin
        if (!resetn || soft_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            idle_q <= 1'b1;
        end else begin
            if (do_wr_c) wr_ptr <= wr_ptr + PW'(1);
            if (do_rd_c) begin
                rd_ptr <= rd_ptr + PW'(1);
                idle_q <= 1'b0;
                if (rd_word_c[WIDTH])
                    count <= ROUTER_CNT_W'(rd_word_c[HDR_LEN_MSB:HDR_LEN_LSB]) + ROUTER_CNT_W'(1);
                else if (count != '0)
                    count <= count - ROUTER_CNT_W'(1);
            end else if (count == '0) begin
                idle_q <= 1'b1;
            end
        end
    end

`ifdef ROUTER_FIFO_HIZ_EN
    assign bus.data_out = idle_q ? {WIDTH{1'bz}} : rd_data;
`else
    assign bus.data_out = idle_q ? '0 : rd_data;
`endif
endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo; honours ROUTER_FIFO_HIZ_EN for the idle value.
module tb_router_fifo;
    import router_pkg::*;

`ifdef ROUTER_FIFO_HIZ_EN
    localparam logic [7:0] IDLE = 8'hzz;
`else
    localparam logic [7:0] IDLE = 8'h00;
`endif

    logic clock = 1'b0;
    logic resetn;
    logic soft_reset;
    int   total = 0;
    int   bad   = 0;

    router_fifo_if #(.WIDTH(8)) bus ();

    router_fifo dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.write_enb = 1'b0;
        bus.read_enb  = 1'b0;
        bus.lfd_state = 1'b0;
        bus.data_in   = 8'h00;
    endtask

    task automatic test_reset();
        idle_inputs();
        soft_reset = 1'b0;
        resetn     = 1'b0;
        tick();
        tick();
        total++;
        if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", bus.empty); end
        total++;
        if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", bus.full); end
        total++;
        if (bus.data_out !== IDLE) begin bad++; $display("FAIL reset_data_out got=%h want=%h", bus.data_out, IDLE); end
        total++;
        if (dut.count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", dut.count); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single_packet();
        logic [7:0] pkt [4];
        logic [5:0] cnt [4];
        pkt[0] = 8'h0A; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h39;
        cnt[0] = 6'd3;  cnt[1] = 6'd2;  cnt[2] = 6'd1;  cnt[3] = 6'd0;
        for (int i = 0; i < 4; i++) begin
            bus.write_enb = 1'b1;
            bus.lfd_state = (i == 0);
            bus.data_in   = pkt[i];
            tick();
            if (i == 0) begin
                total++;
                if (bus.empty !== 1'b0) begin bad++; $display("FAIL single_empty_deassert got=%b want=0", bus.empty); end
            end
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            bus.read_enb = 1'b1;
            tick();
            total++;
            if (bus.data_out !== pkt[i]) begin bad++; $display("FAIL single_data[%0d] got=%h want=%h", i, bus.data_out, pkt[i]); end
            total++;
            if (dut.count !== cnt[i]) begin bad++; $display("FAIL single_count[%0d] got=%0d want=%0d", i, dut.count, cnt[i]); end
        end
        bus.read_enb = 1'b0;
        tick();
        total++;
        if (bus.data_out !== IDLE) begin bad++; $display("FAIL single_idle got=%h want=%h", bus.data_out, IDLE); end
        total++;
        if (bus.empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%b want=1", bus.empty); end
    endtask

    task automatic test_fill_wrap();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            bus.write_enb = 1'b1;
            bus.data_in   = 8'h40 + 8'(i);
            tick();
        end
        total++;
        if (bus.full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", bus.full); end
        bus.data_in = 8'hFF;
        tick();
        total++;
        if (dut.wr_ptr !== 5'd20) begin bad++; $display("FAIL fill_drop_wr_ptr got=%0d want=20", dut.wr_ptr); end
        bus.write_enb = 1'b0;
        bus.read_enb  = 1'b1;
        tick();
        total++;
        if (bus.data_out !== 8'h40) begin bad++; $display("FAIL fill_read1 got=%h want=40", bus.data_out); end
        total++;
        if (bus.full !== 1'b0) begin bad++; $display("FAIL fill_not_full got=%b want=0", bus.full); end
        bus.read_enb  = 1'b0;
        bus.write_enb = 1'b1;
        bus.data_in   = 8'h50;
        tick();
        total++;
        if (bus.full !== 1'b1) begin bad++; $display("FAIL fill_refull got=%b want=1", bus.full); end
        bus.write_enb = 1'b0;
        bus.read_enb  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = (i == 15) ? 8'h50 : 8'h41 + 8'(i);
            tick();
            total++;
            if (bus.data_out !== exp) begin bad++; $display("FAIL wrap_data[%0d] got=%h want=%h", i, bus.data_out, exp); end
        end
        bus.read_enb = 1'b0;
        total++;
        if (bus.empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b want=1", bus.empty); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            bus.write_enb = 1'b1;
            bus.data_in   = 8'h60 + 8'(i);
            tick();
        end
        bus.read_enb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.data_in = 8'h65 + 8'(i);
            tick();
            total++;
            if (bus.data_out !== 8'h60 + 8'(i)) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, bus.data_out, 8'h60 + 8'(i)); end
            total++;
            if (5'(dut.wr_ptr - dut.rd_ptr) !== 5'd5) begin bad++; $display("FAIL b2b_occupancy[%0d] got=%0d want=5", i, 5'(dut.wr_ptr - dut.rd_ptr)); end
        end
        bus.write_enb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (bus.data_out !== 8'h6A + 8'(i)) begin bad++; $display("FAIL b2b_drain[%0d] got=%h want=%h", i, bus.data_out, 8'h6A + 8'(i)); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_soft_reset();
        logic [7:0] pkt [4];
        logic [7:0] np  [3];
        logic [5:0] ncnt [3];
        pkt[0] = 8'h20; pkt[1] = 8'hA1; pkt[2] = 8'hA2; pkt[3] = 8'hA3;
        np[0]  = 8'h04; np[1]  = 8'h77; np[2]  = 8'h73;
        ncnt[0] = 6'd2; ncnt[1] = 6'd1; ncnt[2] = 6'd0;
        for (int i = 0; i < 4; i++) begin
            bus.write_enb = 1'b1;
            bus.lfd_state = (i == 0);
            bus.data_in   = pkt[i];
            tick();
        end
        idle_inputs();
        bus.read_enb = 1'b1;
        tick();
        total++;
        if (dut.count !== 6'd9) begin bad++; $display("FAIL sr_hdr_count got=%0d want=9", dut.count); end
        tick();
        total++;
        if (bus.data_out !== 8'hA1) begin bad++; $display("FAIL sr_payload got=%h want=a1", bus.data_out); end
        bus.read_enb = 1'b0;
        soft_reset   = 1'b1;
        tick();
        soft_reset = 1'b0;
        total++;
        if (bus.empty !== 1'b1) begin bad++; $display("FAIL sr_empty got=%b want=1", bus.empty); end
        total++;
        if (dut.count !== 6'd0) begin bad++; $display("FAIL sr_count got=%0d want=0", dut.count); end
        total++;
        if (bus.data_out !== IDLE) begin bad++; $display("FAIL sr_idle got=%h want=%h", bus.data_out, IDLE); end
        for (int i = 0; i < 3; i++) begin
            bus.write_enb = 1'b1;
            bus.lfd_state = (i == 0);
            bus.data_in   = np[i];
            tick();
        end
        idle_inputs();
        bus.read_enb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.data_out !== np[i]) begin bad++; $display("FAIL sr_new_data[%0d] got=%h want=%h", i, bus.data_out, np[i]); end
            total++;
            if (dut.count !== ncnt[i]) begin bad++; $display("FAIL sr_new_count[%0d] got=%0d want=%0d", i, dut.count, ncnt[i]); end
        end
        bus.read_enb = 1'b0;
        tick();
    endtask

    task automatic test_read_empty();
        bus.read_enb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (dut.rd_ptr !== 5'd3) begin bad++; $display("FAIL re_rd_ptr[%0d] got=%0d want=3", i, dut.rd_ptr); end
            total++;
            if (bus.data_out !== IDLE) begin bad++; $display("FAIL re_idle[%0d] got=%h want=%h", i, bus.data_out, IDLE); end
            total++;
            if (bus.empty !== 1'b1) begin bad++; $display("FAIL re_empty[%0d] got=%b want=1", i, bus.empty); end
        end
        bus.read_enb = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_fill_wrap();
        test_back_to_back();
        test_soft_reset();
        test_read_empty();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
